// File: rtl/mul_u2_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_u2_seq
// Description : Sequential signed (two's-complement) multiplier. It uses a
//               shift-add loop on operand magnitudes over M cycles and then
//               applies the product sign. It reports the low M bits of the
//               signed product and a flag for signed overflow.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset
//               start  - launch request, sampled only in IDLE
//               a, b   - M-bit U2 multiplicand / multiplier
//               busy   - high while iterating
//               done   - one-cycle pulse, result/ERROR valid from this cycle
//               result - low M bits of the signed product (U2), registered
//               ERROR  - product does not fit in M-bit U2, registered
// Revision    : 1.0 - initial release
// ============================================================================
module mul_u2_seq #(
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] result,
    output logic         ERROR
);

    // The counter holds values up to M, so it needs enough bits for M itself.
    localparam int c_CW = $clog2(M + 1);
    localparam logic [c_CW-1:0]  c_LAST    = c_CW'(M - 1);
    localparam logic [c_CW-1:0]  c_CNT_ONE = c_CW'(1);
    localparam logic [M-1:0]     c_ONE_M   = M'(1);
    // 2^(M-1) is the largest magnitude a negative M-bit U2 value can have.
    localparam logic [2*M-1:0]   c_HALF    = {{M{1'b0}}, 1'b1, {(M-1){1'b0}}};
    localparam logic [2*M-1:0]   c_HALF_M1 = {{(M+1){1'b0}}, {(M-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [c_CW-1:0] cnt_q,    cnt_d;
    logic [2*M-1:0]  mcand_q,  mcand_d;
    logic [M-1:0]    mplier_q, mplier_d;
    logic [2*M-1:0]  acc_q,    acc_d;
    logic            sign_q,   sign_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;
    logic [M-1:0]    result_q, result_d;
    logic            error_q,  error_d;

    logic [M-1:0]    w_abs_a;
    logic [M-1:0]    w_abs_b;
    logic [2*M-1:0]  w_acc_sum;
    logic            w_sign_eff;
    logic [M-1:0]    w_res;
    logic            w_err;

    // Magnitudes fit in M unsigned bits, including |-2^(M-1)| = 2^(M-1).
    assign w_abs_a = a[M-1] ? (~a + c_ONE_M) : a;
    assign w_abs_b = b[M-1] ? (~b + c_ONE_M) : b;

    // Accumulator value after the current iteration. On the last iteration
    // this is the final magnitude P, so the output is formed from it directly.
    assign w_acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // A zero product is always reported as positive.
    assign w_sign_eff = sign_q & (w_acc_sum != '0);

    // The low M bits of -P depend only on the low M bits of P.
    assign w_res = w_sign_eff ? (~w_acc_sum[M-1:0] + c_ONE_M) : w_acc_sum[M-1:0];
    assign w_err = w_sign_eff ? (w_acc_sum > c_HALF) : (w_acc_sum > c_HALF_M1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d   = a[M-1] ^ b[M-1];
                    mcand_d  = {{M{1'b0}}, w_abs_a};
                    mplier_d = w_abs_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = w_acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + c_CNT_ONE;
                if (cnt_q == c_LAST) begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = w_res;
                    error_d  = w_err;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ERROR  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_u2_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_u2_seq
// Description : Self-checking bench for mul_u2_seq. An arithmetic model
//               predicts busy/done/result/ERROR every cycle. Directed
//               operations also check hand-computed literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_u2_seq;

    localparam int M = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         busy;
    logic         done;
    logic [M-1:0] result;
    logic         ERROR;

    int checks = 0;
    int errors = 0;

    mul_u2_seq #(.M(M)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ERROR  (ERROR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: an accepted start launches an operation that completes M+1
    // cycles later. The product comes from plain signed integer arithmetic.
    // ------------------------------------------------------------------
    int           remaining = 0;  // 0 means idle; 1 means done cycle
    int           mp;
    logic [M-1:0] m_result  = '0;
    logic         m_err     = 1'b0;
    logic [M-1:0] m_pend_res;
    logic         m_pend_err;
    bit           chk_en    = 1'b0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            remaining = 0;
            m_result  = '0;
            m_err     = 1'b0;
        end else if (remaining == 0) begin
            if (start === 1'b1) begin
                mp         = $signed(a) * $signed(b);
                m_pend_res = mp[M-1:0];
                m_pend_err = (mp > (2**(M-1) - 1)) || (mp < -(2**(M-1)));
                remaining  = M + 1;
            end
        end else begin
            remaining--;
            if (remaining == 1) begin
                m_result = m_pend_res;
                m_err    = m_pend_err;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   busy,   (remaining >= 2) ? 1 : 0);
            chk("done",   done,   (remaining == 1) ? 1 : 0);
            chk("result", result, m_result);
            chk("error",  ERROR,  m_err);
            chk("busy_done_exclusive", busy & done, 0);
        end
    end

    // Counts negedges until done is seen, up to a bound. lat is 0 on timeout.
    task automatic wait_done(input int bound, output int lat);
        lat = 0;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string nm, input logic [M-1:0] ia, input logic [M-1:0] ib,
                          input logic [M-1:0] er, input logic ee);
        int lat;
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        wait_done(M + 6, lat);
        chk({nm, "_latency"}, lat, M + 1);
        chk({nm, "_result"},  result, er);
        chk({nm, "_error"},   ERROR, ee);
        chk({nm, "_model"},   {m_err, m_result}, {ee, er});
    endtask

    initial begin
        int lat;
        bit saw_done;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   busy,   0);
        chk("reset_done",   done,   0);
        chk("reset_result", result, 0);
        chk("reset_error",  ERROR,  0);
        chk_en = 1'b1;
        rst    = 1'b0;

        run_op("p5_m3",     8'h05, 8'hFD, 8'hF1, 1'b0);
        run_op("m128_p1",   8'h80, 8'h01, 8'h80, 1'b0);
        run_op("m128_m1",   8'h80, 8'hFF, 8'h80, 1'b1);
        run_op("p16_p16",   8'h10, 8'h10, 8'h00, 1'b1);
        run_op("zero_m7",   8'h00, 8'hF9, 8'h00, 1'b0);
        run_op("max_max",   8'h7F, 8'h7F, 8'h01, 1'b1);
        run_op("m64_p2",    8'hC0, 8'h02, 8'h80, 1'b0);
        run_op("p64_p2",    8'h40, 8'h02, 8'h80, 1'b1);
        run_op("m1_p1",     8'hFF, 8'h01, 8'hFF, 1'b0);

        // A start in the middle of an operation is ignored, and operand
        // changes after acceptance have no effect.
        @(negedge clk);
        a = 8'h05; b = 8'hFD; start = 1'b1;          // sampled at edge t
        @(negedge clk); start = 1'b0; a = 8'h77;     // cycle t+1
        @(negedge clk);                              // t+2
        @(negedge clk); a = 8'h02; b = 8'h02; start = 1'b1;  // t+3
        wait_done(M + 4, lat);                       // done expected at t+9
        chk("ign_start_latency", lat, 6);
        chk("ign_start_result",  result, 8'hF1);
        chk("ign_start_error",   ERROR, 0);

        // Reset during an operation aborts it without a done pulse.
        @(negedge clk);
        a = 8'h05; b = 8'hFD; start = 1'b1;          // edge t
        @(negedge clk); start = 1'b0;                // t+1
        @(negedge clk);                              // t+2
        @(negedge clk);                              // t+3
        @(negedge clk); rst = 1'b1;                  // t+4
        @(negedge clk); rst = 1'b0;                  // t+5
        chk("abort_busy",   busy,   0);
        chk("abort_done",   done,   0);
        chk("abort_result", result, 0);
        chk("abort_error",  ERROR,  0);
        saw_done = 1'b0;
        for (int n = 0; n < M + 3; n++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);

        run_op("m1_m1",     8'hFF, 8'hFF, 8'h01, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
